// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter:
// FSM states, port IDs, default widths and the read-latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_CNT_W  = 3;

  // Wait-counter preload: WAIT runs RD_LAT cycles, counting down to zero.
  function automatic logic [LAT_CNT_W-1:0] wait_load(input int rd_lat);
    return LAT_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant. On a tie the port that did
// not own the previous access wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  // Grant decode: bit 0 is the CPU, bit 1 the loader.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_id  = PORT_CPU;
    case (i_req)
      2'b01: begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = PORT_CPU;
      end
      2'b10: begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = PORT_LDR;
      end
      2'b11: begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = ~i_last;
      end
      default: begin
        o_gnt_vld = 1'b0;
        o_gnt_id  = PORT_CPU;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory controller sharing one synchronous single-port memory between the
// CPU core and the loader/debug port, with a ready handshake per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  input  logic              ldr_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  arb_state_t           r_state;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [DATA_W-1:0]    r_cpu_rdata;
  logic [DATA_W-1:0]    r_ldr_rdata;
  logic                 r_cpu_ready;
  logic                 r_ldr_ready;
  logic                 r_owner;
  logic                 r_busy;
  logic [LAT_CNT_W-1:0] r_cnt;

  logic [1:0]           w_req;
  logic                 w_gnt_vld;
  logic                 w_gnt_id;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  // The lock masks the CPU request before arbitration, so a lock rising in
  // the same cycle as a CPU request always wins.
  assign w_req = {ldr_req, cpu_req & ~ldr_lock};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_last    (r_owner),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  // Grantee's access fields, captured into the memory registers at grant.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = {ADDR_W{1'b0}};
    w_sel_wdata = {DATA_W{1'b0}};
    if (w_gnt_id == PORT_LDR) begin
      w_sel_we    = ldr_we;
      w_sel_addr  = ldr_addr;
      w_sel_wdata = ldr_wdata;
    end else begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end
  end

  // Access FSM with registered memory strobes and ready pulses; ready is
  // raised on the edge into DONE so it lines up with the captured rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_cpu_rdata <= {DATA_W{1'b0}};
      r_ldr_rdata <= {DATA_W{1'b0}};
      r_cpu_ready <= 1'b0;
      r_ldr_ready <= 1'b0;
      r_owner     <= PORT_LDR;
      r_busy      <= 1'b0;
      r_cnt       <= {LAT_CNT_W{1'b0}};
    end else begin
      r_cpu_ready <= 1'b0;
      r_ldr_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_owner     <= w_gnt_id;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_cpu_ready <= (r_owner == PORT_CPU);
            r_ldr_ready <= (r_owner == PORT_LDR);
            r_state     <= DONE;
          end else begin
            r_cnt   <= wait_load(RD_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != {LAT_CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            if (r_owner == PORT_LDR) begin
              r_ldr_rdata <= mem_rdata;
              r_ldr_ready <= 1'b1;
            end else begin
              r_cpu_rdata <= mem_rdata;
              r_cpu_ready <= 1'b1;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_ready = r_cpu_ready;
  assign ldr_ready = r_ldr_ready;
  assign owner     = r_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// transactions checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int RL1 = 1;
  localparam int RL4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with RD_LAT=1
  logic          reset, cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic          cpu_ready, ldr_ready, mem_en, mem_we, owner, busy;

  // DUT with RD_LAT=4
  logic          d4_reset, d4_cpu_req, d4_cpu_we, d4_ldr_req, d4_ldr_we, d4_ldr_lock;
  logic [AW-1:0] d4_cpu_addr, d4_ldr_addr, d4_mem_addr;
  logic [DW-1:0] d4_cpu_wdata, d4_ldr_wdata, d4_cpu_rdata, d4_ldr_rdata, d4_mem_wdata, d4_mem_rdata;
  logic          d4_cpu_ready, d4_ldr_ready, d4_mem_en, d4_mem_we, d4_owner, d4_busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready), .ldr_lock(ldr_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL4)) u_dut4 (
    .clk(clk), .reset(d4_reset),
    .cpu_req(d4_cpu_req), .cpu_we(d4_cpu_we), .cpu_addr(d4_cpu_addr), .cpu_wdata(d4_cpu_wdata),
    .cpu_rdata(d4_cpu_rdata), .cpu_ready(d4_cpu_ready),
    .ldr_req(d4_ldr_req), .ldr_we(d4_ldr_we), .ldr_addr(d4_ldr_addr), .ldr_wdata(d4_ldr_wdata),
    .ldr_rdata(d4_ldr_rdata), .ldr_ready(d4_ldr_ready), .ldr_lock(d4_ldr_lock),
    .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
    .mem_rdata(d4_mem_rdata), .owner(d4_owner), .busy(d4_busy)
  );

  // Power-on memory contents; address 9216 holds the pattern used in the first read.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 24'd9216) return 16'hA5C3;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural synchronous memories; a wrongly timed capture sees 16'hDEAD.
  logic [DW-1:0] mem1 [65536];
  bit            wr1  [65536];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe4 [4];
  assign mem_rdata    = pipe1;
  assign d4_mem_rdata = pipe4[3];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem1[mem_addr[15:0]] <= mem_wdata;
      wr1[mem_addr[15:0]]  <= 1'b1;
    end
    if (mem_en && !mem_we) pipe1 <= wr1[mem_addr[15:0]] ? mem1[mem_addr[15:0]] : init_val(mem_addr);
    else                   pipe1 <= 16'hDEAD;
  end

  always @(posedge clk) begin
    pipe4[0] <= (d4_mem_en && !d4_mem_we) ? init_val(d4_mem_addr) : 16'hDEAD;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end

  // Passive monitor: mem_en cycles and ready overlaps on the RD_LAT=1 DUT.
  int en_q[$];
  int overlap = 0;
  always @(negedge clk) begin
    if (mem_en) en_q.push_back(cyc);
    if (cpu_ready && ldr_ready) overlap <= overlap + 1;
  end

  // Reference model state
  int          n_checks = 0;
  int          n_errors = 0;
  bit          last_owner;
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] shadow [logic [AW-1:0]];

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  // Round robin: a tie goes to whoever did not have the last access.
  function automatic bit rr_expect(input bit c_el, input bit l_el, input bit last);
    if (c_el && l_el) return !last;
    return l_el;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 1) == 0 ? 24'h00F000 : 24'h80F100) + 24'($urandom_range(0, 7));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut1();
    reset = 1'b1;
    cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_owner = 1'b1;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
  endtask

  // One full access on the RD_LAT=1 DUT, starting in an IDLE cycle with
  // requests already driven; ends in the next IDLE cycle.
  task automatic run_txn(input bit drop_req);
    bit            c_el, l_el, gp, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            lat;
    c_el   = cpu_req && !ldr_lock;
    l_el   = ldr_req;
    gp     = rr_expect(c_el, l_el, last_owner);
    e_we   = gp ? ldr_we : cpu_we;
    e_addr = gp ? ldr_addr : cpu_addr;
    e_wd   = gp ? ldr_wdata : cpu_wdata;
    tick();
    check("mem_en_issue", 32'(mem_en), 32'd1);
    check("owner_grant", 32'(owner), 32'(gp));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("busy_issue", 32'(busy), 32'd1);
    last_owner = gp;
    if (drop_req) begin
      cpu_req = 1'b0;
      ldr_req = 1'b0;
    end
    cpu_addr  = 24'($urandom); ldr_addr  = 24'($urandom);
    cpu_wdata = 16'($urandom); ldr_wdata = 16'($urandom);
    if (e_we) shadow[e_addr] = e_wd;
    lat = e_we ? 2 : 2 + RL1;
    for (int k = 2; k <= lat; k++) begin
      tick();
      if (k == 2) check("mem_en_single", 32'(mem_en), 32'd0);
      if (k < lat) begin
        check("ready_early", 32'({ldr_ready, cpu_ready}), 32'd0);
      end else begin
        check("ready_vec", 32'({ldr_ready, cpu_ready}), gp ? 32'd2 : 32'd1);
        if (!e_we) exp_rd[gp] = shadow_rd(e_addr);
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[0]));
        check("ldr_rdata", 32'(ldr_rdata), 32'(exp_rd[1]));
      end
    end
    tick();
    check("ready_clear", 32'({ldr_ready, cpu_ready}), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  int s_idx;
  int n_en;
  int pulses;

  initial begin
    cpu_we = 1'b0; cpu_addr = 24'd0; cpu_wdata = 16'd0;
    ldr_we = 1'b0; ldr_addr = 24'd0; ldr_wdata = 16'd0;
    d4_cpu_req = 1'b0; d4_cpu_we = 1'b0; d4_cpu_addr = 24'd0; d4_cpu_wdata = 16'd0;
    d4_ldr_req = 1'b0; d4_ldr_we = 1'b0; d4_ldr_addr = 24'd0; d4_ldr_wdata = 16'd0;
    d4_ldr_lock = 1'b0;
    d4_reset = 1'b1;
    reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    tick();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'd0);
    check("rst_ready", 32'({cpu_ready, ldr_ready}), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst4_owner", 32'(d4_owner), 32'd1);
    reset_dut1();
    d4_reset = 1'b0;

    // CPU read of 9216
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'd9216;
    run_txn(1'b1);
    check("read9216_data", 32'(cpu_rdata), 32'h0000A5C3);

    // Loader write 100 <- 1234, then read it back
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 24'd100; ldr_wdata = 16'h1234;
    run_txn(1'b1);
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 24'd100;
    run_txn(1'b1);
    check("read100_data", 32'(ldr_rdata), 32'h00001234);

    // Both requesting continuously after reset: CPU, LDR, CPU, LDR
    reset_dut1();
    cpu_req = 1'b1; ldr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b0; ldr_we = 1'b0;
      cpu_addr = rand_addr(); ldr_addr = rand_addr();
      run_txn(1'b0);
      check("alt_owner", 32'(owner), 32'(i % 2));
    end

    // Lock holds off the CPU for 20 cycles
    ldr_req = 1'b0; ldr_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'd42;
    n_en = en_q.size();
    for (int i = 0; i < 20; i++) tick();
    check("lock_no_grant", 32'(en_q.size() - n_en), 32'd0);
    check("lock_busy", 32'(busy), 32'd0);
    ldr_lock = 1'b0;
    cpu_addr = 24'd42;
    run_txn(1'b1);
    check("unlock_owner", 32'(owner), 32'd0);

    // Back-to-back CPU reads with req held, addresses 0, 1, 2
    s_idx = en_q.size();
    cpu_req = 1'b1; ldr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b0;
      cpu_addr = 24'(i);
      run_txn(1'b0);
    end
    cpu_req = 1'b0;
    check("b2b_count", 32'(en_q.size() - s_idx), 32'd3);
    if (en_q.size() - s_idx >= 3) begin
      check("b2b_space0", 32'(en_q[s_idx + 1] - en_q[s_idx]), 32'(RL1 + 3));
      check("b2b_space1", 32'(en_q[s_idx + 2] - en_q[s_idx + 1]), 32'(RL1 + 3));
    end

    // Random mix of requesters, lock and read/write
    for (int i = 0; i < 40; i++) begin
      cpu_req  = 1'($urandom);
      ldr_req  = 1'($urandom);
      ldr_lock = ($urandom_range(0, 3) == 0);
      if (!(cpu_req && !ldr_lock) && !ldr_req) ldr_req = 1'b1;
      cpu_we = 1'($urandom); ldr_we = 1'($urandom);
      cpu_addr = rand_addr(); ldr_addr = rand_addr();
      cpu_wdata = 16'($urandom); ldr_wdata = 16'($urandom);
      run_txn(1'($urandom));
    end
    cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    tick();
    check("no_ready_overlap", 32'(overlap), 32'd0);

    // RD_LAT=4: full read, ready 6 cycles after grant
    d4_cpu_req = 1'b1; d4_cpu_we = 1'b0; d4_cpu_addr = 24'd5;
    tick();
    d4_cpu_req = 1'b0;
    check("d4_mem_en", 32'(d4_mem_en), 32'd1);
    check("d4_mem_addr", 32'(d4_mem_addr), 32'd5);
    for (int k = 2; k <= 2 + RL4; k++) begin
      tick();
      if (k < 2 + RL4) check("d4_ready_early", 32'(d4_cpu_ready), 32'd0);
      else begin
        check("d4_ready", 32'(d4_cpu_ready), 32'd1);
        check("d4_rdata", 32'(d4_cpu_rdata), 32'(init_val(24'd5)));
      end
    end
    tick();

    // RD_LAT=4: reset in the second WAIT cycle drops the read
    d4_cpu_req = 1'b1; d4_cpu_addr = 24'd7;
    tick();
    d4_cpu_req = 1'b0;
    tick();
    tick();
    check("d4_busy_wait", 32'(d4_busy), 32'd1);
    d4_reset = 1'b1;
    tick();
    d4_reset = 1'b0;
    check("d4_rst_busy", 32'(d4_busy), 32'd0);
    check("d4_rst_rdata", 32'(d4_cpu_rdata), 32'd0);
    check("d4_rst_owner", 32'(d4_owner), 32'd1);
    check("d4_rst_ready", 32'(d4_cpu_ready), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d4_cpu_ready) pulses++;
    end
    check("d4_no_pulse", 32'(pulses), 32'd0);
    check("d4_idle_en", 32'(d4_mem_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester memory controller between the CPU core, the program loader/debug port and the single-port synchronous memory.
- Arbitrates round-robin and registers the address, data and write enable for each access.
- Waits out the fixed memory read latency, then returns read data with a one-cycle ready pulse.
- Supplies the data_ready handshake the core's Fetch and Memory states currently lack.

Parameters:
ADDR_W, 24, address width (matches core's 24-bit address).
DATA_W, 16, data width.
RD_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  CPU access request.
cpu_we  in  1  1=write, 0=read; sampled at grant.
cpu_addr  in  ADDR_W  CPU address; sampled at grant.
cpu_wdata  in  DATA_W  CPU write data; sampled at grant.
cpu_rdata  out  DATA_W  CPU read data; valid when cpu_ready=1, held until next CPU read completes.
cpu_ready  out  1  one-cycle pulse: CPU access complete.
ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ready  same widths and meanings as the CPU group, for the loader port.
ldr_lock  in  1  while high, CPU requests are not granted (program load).
mem_en  out  1  memory access strobe (registered).
mem_we  out  1  memory write enable (registered).
mem_addr  out  ADDR_W  memory address (registered).
mem_wdata  out  DATA_W  memory write data (registered).
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en.
owner  out  1  current or last grantee: 0=CPU, 1=loader.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; mem_en=mem_we=0; mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0; cpu_ready=ldr_ready=0; owner=1 (so the CPU wins the first tie); busy=0; wait counter=0.
- Reset mid-operation: at the sampling edge, all registers return to reset values. An in-flight read is dropped with no ready pulse. A write whose mem_we was high in the reset cycle has already been committed by memory.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Eligible requesters: cpu_req & ~ldr_lock, and ldr_req.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one that is not owner (round-robin).
  - On grant, at the edge: owner <= grantee; mem_addr, mem_wdata, mem_we <= grantee's inputs; mem_en <= 1; go to ISSUE.
- ISSUE (mem_en=1 exactly one cycle):
  - At the edge: mem_en <= 0 and mem_we <= 0.
  - Write: go to DONE.
  - Read: counter <= RD_LAT-1, go to WAIT.
- WAIT:
  - Counter ≠ 0: decrement.
  - Counter = 0: capture mem_rdata into the grantee's rdata register and go to DONE.
- DONE: grantee's ready=1 for this cycle only; go to IDLE. The other port's rdata is untouched.
- Latency, with grant in cycle t:
  - mem_en in cycle t+1.
  - Write ready in cycle t+2.
  - Read ready in cycle t+2+RD_LAT (RD_LAT=1 gives t+3).
  - Minimum spacing between grants: write 3 cycles, read RD_LAT+3 cycles.
- Handshake rules:
  - Requester inputs need be valid only in the grant cycle.
  - req may stay high through ready. It is then a new request, arbitrated in the following IDLE cycle.
  - Dropping req before ready does not cancel the access.
- ldr_lock:
  - Affects grant decisions only; an in-flight CPU access completes normally.
  - If it rises in the same cycle as a CPU grant in IDLE, the lock wins and the CPU is not granted.
- Simultaneous events: no requester ever sees ready while the other's access is in flight. Both ready outputs are never high together.
- Address passes through unmodified; no width arithmetic.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3;
  - port IDs PORT_CPU=1'b0, PORT_LDR=1'b1;
  - default ADDR_W/DATA_W;
  - RD_LAT range limit.
- One natural sub-module: rr_arb2. It is the combinational two-way round-robin grant, taking the request vector and the last-owner bit; the FSM and datapath stay in the top.

Test Plan:
- Reset, then CPU read addr 24'd9216, memory returns 16'hA5C3 with RD_LAT=1 → mem_en high one cycle with mem_addr=9216, mem_we=0; cpu_ready pulses 3 cycles after grant; cpu_rdata=16'hA5C3, ldr_ready stays 0.
- Loader write addr 24'd100, data 16'h1234 → mem_en=mem_we=1 for one cycle with addr 100, data 16'h1234; ldr_ready 2 cycles after grant.
- Both req held high continuously, all reads → grants alternate CPU, LDR, CPU, LDR, with the CPU first after reset; owner toggles each transaction and no ready overlap.
- ldr_lock=1 with cpu_req=1 for 20 cycles, then ldr_lock=0 → no CPU grant while locked; CPU granted in the first IDLE after lock falls.
- RD_LAT=4, CPU read; reset asserted in the second WAIT cycle → next edge gives state IDLE, busy=0, cpu_ready never pulses, cpu_rdata=0.
- CPU keeps req=1 through cpu_ready with changing addresses 0, 1, 2 → three back-to-back reads; each mem_addr equals the address presented in its grant cycle; grants spaced RD_LAT+3 cycles.
